// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_rmw
//  Purpose  : Load/store unit between the MEM stage and a word-only data
//             memory with a 1-cycle registered read. Performs byte/half/word
//             loads with sign or zero extension. Sub-word stores are done as
//             read-modify-write. One response is returned per request.
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_ready handshake; req_we, req_size, req_unsigned,
//             req_addr, req_wdata      - request fields (latched on accept)
//             resp_valid, resp_rdata, resp_err - one-cycle response pulse
//             dm_addr, dm_wr, dm_din, dm_dout   - data memory port
//  Config   : `define LSU_BOUNDS_CHK_EN enables the address window check
//             [BASE_ADDR, BASE_ADDR + 4*2**DM_AW). Without it, the upper
//             address bits are ignored and addresses alias into the DM.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_rmw #(
  parameter int          DM_AW     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_wr,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic              dm_wr_q;
  logic [DM_AW-1:0]  dm_addr_q;
  logic [31:0]       dm_din_q;

  // Request fields captured on accept
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;

  // --------------------------------------------------------------------------
  // Request decode (on the live request inputs)
  // --------------------------------------------------------------------------
  logic              misalign_d;
  logic              oob_d;
  logic              err_d;
  logic [DM_AW-1:0]  word_addr_d;

  assign misalign_d = ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || (req_size == 2'b11);

`ifdef LSU_BOUNDS_CHK_EN
  logic [31:0] offset_d;
  logic        unused_offset_lsb;
  assign offset_d          = req_addr - BASE_ADDR;
  // Below the base wraps to a huge offset, so the upper-bits test alone
  // would catch it; the explicit compare keeps the intent obvious.
  assign oob_d             = (req_addr < BASE_ADDR) || (offset_d[31:DM_AW+2] != '0);
  assign word_addr_d       = offset_d[DM_AW+1:2];
  assign unused_offset_lsb = ^offset_d[1:0];
`else
  logic unused_hi_addr;
  assign oob_d          = 1'b0;
  assign word_addr_d    = req_addr[DM_AW+1:2];
  assign unused_hi_addr = ^{req_addr[31:DM_AW+2], BASE_ADDR};
`endif

  assign err_d = misalign_d || oob_d;

  // --------------------------------------------------------------------------
  // Lane handling on the captured read word
  // --------------------------------------------------------------------------
  logic [4:0]  lane_sh_d;
  logic [31:0] shifted_d;
  logic [31:0] load_d;
  logic [31:0] mask_d;
  logic [31:0] merged_d;

  assign lane_sh_d = {lane_q, 3'b000};
  assign shifted_d = dm_dout >> lane_sh_d;

  always_comb begin
    load_d = dm_dout;
    case (size_q)
      SZ_BYTE: load_d = uns_q ? {24'h0, shifted_d[7:0]}
                              : {{24{shifted_d[7]}}, shifted_d[7:0]};
      SZ_HALF: load_d = uns_q ? {16'h0, shifted_d[15:0]}
                              : {{16{shifted_d[15]}}, shifted_d[15:0]};
      default: load_d = dm_dout;
    endcase
  end

  // Only byte and half stores reach the merge path; halves are aligned, so
  // shifting by 8*lane places them at 16*addr[1].
  assign mask_d   = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh_d;
  assign merged_d = (dm_dout & ~mask_d) | ((wdata_q << lane_sh_d) & mask_d);

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      dm_wr_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_din_q     <= 32'h0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE, S_RSP: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            uns_q        <= req_unsigned;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata;
            resp_rdata_q <= 32'h0;
            if (err_d) begin
              // Errors skip the DM entirely and respond next cycle
              state_q      <= S_RSP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              req_ready_q  <= 1'b1;
            end else begin
              dm_addr_q    <= word_addr_d;
              resp_valid_q <= 1'b0;
              resp_err_q   <= 1'b0;
              req_ready_q  <= 1'b0;
              if (req_we && (req_size == SZ_WORD)) begin
                dm_din_q <= req_wdata;
                dm_wr_q  <= 1'b1;
                state_q  <= S_WR;
              end else begin
                state_q  <= S_RD;
              end
            end
          end else begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          if (we_q) begin
            dm_din_q <= merged_d;
            dm_wr_q  <= 1'b1;
            state_q  <= S_WR;
          end else begin
            resp_rdata_q <= load_d;
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= S_RSP;
          end
        end
        S_WR: begin
          dm_wr_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= S_RSP;
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          dm_wr_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dm_wr      = dm_wr_q;
  assign dm_addr    = dm_addr_q;
  assign dm_din     = dm_din_q;

endmodule
`default_nettype wire
